// File: rtl/gpio_rmw_arbiter_if.sv
// Bundle of fabric-side request/response signals and the Avalon-MM
// master signals toward the 12-bit GPIO slave.
//   slave  modport: seen by gpio_rmw_arbiter (takes requests, drives the bus)
//   master modport: seen by the requesters / environment (drives requests,
//                   returns gpio_readdata)
// Signals: req, req_op, req_mask, req_data, ack, rsp_data, rsp_timeout,
//          gpio_address, gpio_chipselect, gpio_write_n, gpio_writedata,
//          gpio_readdata.
interface gpio_rmw_arbiter_if #(
    parameter int WIDTH = 12
);
    logic [1:0]         req;
    logic [3:0]         req_op;
    logic [2*WIDTH-1:0] req_mask;
    logic [2*WIDTH-1:0] req_data;
    logic [1:0]         ack;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_timeout;
    logic [1:0]         gpio_address;
    logic               gpio_chipselect;
    logic               gpio_write_n;
    logic [31:0]        gpio_writedata;
    logic [31:0]        gpio_readdata;

    modport slave (
        input  req, req_op, req_mask, req_data, gpio_readdata,
        output ack, rsp_data, rsp_timeout,
        output gpio_address, gpio_chipselect, gpio_write_n, gpio_writedata
    );

    modport master (
        output req, req_op, req_mask, req_data, gpio_readdata,
        input  ack, rsp_data, rsp_timeout,
        input  gpio_address, gpio_chipselect, gpio_write_n, gpio_writedata
    );
endinterface

// File: rtl/gpio_rmw_arbiter.sv
// Round-robin arbiter and Avalon-MM master for a bidirectional GPIO slave.
// Two requesters issue WRITE_OUT / WRITE_DIR (masked read-modify-write on
// shadow copies of the slave's output latch and direction register),
// READ_PINS and WAIT_PINS (poll until masked pins match, optional timeout).
// Ports: clk, reset_n (async, active low), bus (gpio_rmw_arbiter_if.slave).
// Every output is registered.
module gpio_rmw_arbiter #(
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    gpio_rmw_arbiter_if.slave  bus
);
    localparam logic [1:0] OP_WRITE_OUT = 2'd0;
    localparam logic [1:0] OP_WRITE_DIR = 2'd1;
    localparam logic [1:0] OP_READ_PINS = 2'd2;
    localparam logic [1:0] OP_WAIT_PINS = 2'd3;
    localparam logic [TO_W-1:0] TIMEOUT_C  = TO_W'(TIMEOUT);
    localparam logic            TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_RESP = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t           state_r;
    logic             rr_last_r;
    logic             owner_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] res_r;
    logic             to_r;
    logic [WIDTH-1:0] shadow_out_r;
    logic [WIDTH-1:0] shadow_dir_r;
    logic [TO_W-1:0]  poll_cnt_r;
    logic [1:0]       ack_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_timeout_r;
    logic [1:0]       gpio_address_r;
    logic             gpio_chipselect_r;
    logic             gpio_write_n_r;
    logic [31:0]      gpio_writedata_r;

    logic             grant_s;
    logic             win_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH-1:0] sel_mask_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [WIDTH-1:0] sel_shadow_s;
    logic [WIDTH-1:0] new_val_s;
    logic [WIDTH-1:0] pins_s;
    logic             match_s;
    logic [TO_W-1:0]  poll_next_s;
    logic             timeout_s;
    logic             unused_readdata_s;

    // Upper slave read bits carry nothing for a WIDTH-bit port.
    assign unused_readdata_s = ^bus.gpio_readdata[31:WIDTH];

    // Arbitration, winner selection, RMW value and poll comparison.
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        case (bus.req)
            2'b01:   begin grant_s = 1'b1; win_s = 1'b0;       end
            2'b10:   begin grant_s = 1'b1; win_s = 1'b1;       end
            2'b11:   begin grant_s = 1'b1; win_s = ~rr_last_r; end
            default: begin grant_s = 1'b0; win_s = 1'b0;       end
        endcase
        sel_op_s     = win_s ? bus.req_op[3:2] : bus.req_op[1:0];
        sel_mask_s   = win_s ? bus.req_mask[2*WIDTH-1:WIDTH] : bus.req_mask[WIDTH-1:0];
        sel_data_s   = win_s ? bus.req_data[2*WIDTH-1:WIDTH] : bus.req_data[WIDTH-1:0];
        sel_shadow_s = (sel_op_s == OP_WRITE_DIR) ? shadow_dir_r : shadow_out_r;
        new_val_s    = (sel_shadow_s & ~sel_mask_s) | (sel_data_s & sel_mask_s);
        pins_s       = bus.gpio_readdata[WIDTH-1:0] & mask_r;
        match_s      = (pins_s == (data_r & mask_r));
        // Saturating poll counter; only meaningful up to TIMEOUT.
        poll_next_s  = (poll_cnt_r == {TO_W{1'b1}}) ? poll_cnt_r
                                                    : poll_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        timeout_s    = TIMEOUT_EN && (poll_next_s == TIMEOUT_C);
    end

    // Operation sequencer: grant, bus cycles, shadow update, response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r           <= ST_IDLE;
            rr_last_r         <= 1'b1;
            owner_r           <= 1'b0;
            op_r              <= 2'd0;
            mask_r            <= '0;
            data_r            <= '0;
            res_r             <= '0;
            to_r              <= 1'b0;
            shadow_out_r      <= '0;
            shadow_dir_r      <= '0;
            poll_cnt_r        <= '0;
            ack_r             <= 2'b00;
            rsp_data_r        <= '0;
            rsp_timeout_r     <= 1'b0;
            gpio_address_r    <= 2'd0;
            gpio_chipselect_r <= 1'b0;
            gpio_write_n_r    <= 1'b1;
            gpio_writedata_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 2'b00;
                    if (grant_s) begin
                        rr_last_r  <= win_s;
                        owner_r    <= win_s;
                        op_r       <= sel_op_s;
                        mask_r     <= sel_mask_s;
                        data_r     <= sel_data_s;
                        to_r       <= 1'b0;
                        poll_cnt_r <= '0;
                        if (!sel_op_s[1]) begin
                            res_r             <= new_val_s;
                            gpio_address_r    <= (sel_op_s == OP_WRITE_DIR) ? 2'd1 : 2'd0;
                            gpio_chipselect_r <= 1'b1;
                            gpio_write_n_r    <= 1'b0;
                            gpio_writedata_r  <= {{(32-WIDTH){1'b0}}, new_val_s};
                            state_r           <= ST_WR;
                        end else begin
                            gpio_address_r <= 2'd0;
                            state_r        <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    // The slave latches the write on this edge, so the shadow follows it.
                    if (op_r == OP_WRITE_DIR) begin
                        shadow_dir_r <= res_r;
                    end else begin
                        shadow_out_r <= res_r;
                    end
                    gpio_address_r    <= 2'd0;
                    gpio_chipselect_r <= 1'b0;
                    gpio_write_n_r    <= 1'b1;
                    gpio_writedata_r  <= 32'd0;
                    state_r           <= ST_RESP;
                end
                ST_RD: begin
                    // Slave registers pin levels on this edge.
                    state_r <= ST_CAP;
                end
                ST_CAP: begin
                    res_r <= pins_s;
                    if ((op_r == OP_READ_PINS) || match_s) begin
                        state_r <= ST_RESP;
                    end else if (timeout_s) begin
                        to_r    <= 1'b1;
                        state_r <= ST_RESP;
                    end else begin
                        poll_cnt_r <= poll_next_s;
                        state_r    <= ST_RD;
                    end
                end
                ST_RESP: begin
                    ack_r         <= owner_r ? 2'b10 : 2'b01;
                    rsp_data_r    <= res_r;
                    rsp_timeout_r <= to_r;
                    state_r       <= ST_DONE;
                end
                ST_DONE: begin
                    ack_r   <= 2'b00;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack_r             <= 2'b00;
                    gpio_chipselect_r <= 1'b0;
                    gpio_write_n_r    <= 1'b1;
                    state_r           <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack             = ack_r;
    assign bus.rsp_data        = rsp_data_r;
    assign bus.rsp_timeout     = rsp_timeout_r;
    assign bus.gpio_address    = gpio_address_r;
    assign bus.gpio_chipselect = gpio_chipselect_r;
    assign bus.gpio_write_n    = gpio_write_n_r;
    assign bus.gpio_writedata  = gpio_writedata_r;
endmodule

// File: tb/tb_gpio_rmw_arbiter.sv
// Self-checking bench for gpio_rmw_arbiter with a behavioural GPIO slave.
// Expected responses are pushed to a scoreboard queue when a request is
// driven and popped when the matching ack appears.
module tb_gpio_rmw_arbiter;
    localparam int W = 12;
    localparam int TB_TIMEOUT = 8;
    localparam logic [1:0] WR_OUT = 2'd0, WR_DIR = 2'd1, RD_PINS = 2'd2, WT_PINS = 2'd3;
    localparam logic [50:0] RST_VEC = {2'b00, 12'h000, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0};

    typedef logic [14:0] rsp_t; // {ack[1:0], rsp_data[11:0], rsp_timeout}

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    gpio_rmw_arbiter_if #(.WIDTH(W)) bus ();

    gpio_rmw_arbiter #(.WIDTH(W), .TIMEOUT(TB_TIMEOUT), .TO_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // GPIO slave model: output latch, direction, registered readdata.
    logic [W-1:0] slv_out, slv_dir, ext_pins;
    logic [31:0]  rd_r;
    wire  [W-1:0] pins = (slv_dir & slv_out) | (~slv_dir & ext_pins);
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slv_out <= '0; slv_dir <= '0; rd_r <= 32'd0;
        end else begin
            if (bus.gpio_chipselect && !bus.gpio_write_n) begin
                if (bus.gpio_address == 2'd0) slv_out <= bus.gpio_writedata[W-1:0];
                else if (bus.gpio_address == 2'd1) slv_dir <= bus.gpio_writedata[W-1:0];
            end
            // Junk in the upper bits: the arbiter must ignore them.
            rd_r <= (bus.gpio_address == 2'd0) ? {20'hABCDE, pins} : {20'hABCDE, slv_dir};
        end
    end
    assign bus.gpio_readdata = rd_r;

    // Write monitor.
    int wr_cnt = 0, b2b_cnt = 0;
    logic [1:0] last_addr = 2'd0;
    logic [31:0] last_data = 32'd0;
    logic prev_wr = 1'b0;
    always @(posedge clk) begin
        prev_wr <= bus.gpio_chipselect && !bus.gpio_write_n;
        if (bus.gpio_chipselect && !bus.gpio_write_n) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= bus.gpio_address;
            last_data <= bus.gpio_writedata;
            if (prev_wr) b2b_cnt <= b2b_cnt + 1;
        end
    end

    int checks = 0, passes = 0;
    rsp_t sb_q[$];
    logic [W-1:0] exp_out = '0, exp_dir = '0;

    function automatic logic [W-1:0] rmw(input logic [W-1:0] old, input logic [W-1:0] m, input logic [W-1:0] d);
        return (old & ~m) | (d & m);
    endfunction

    task automatic issue(input int r, input logic [1:0] op, input logic [W-1:0] m, input logic [W-1:0] d);
        bus.req_op[r*2 +: 2] = op;
        bus.req_mask[r*W +: W] = m;
        bus.req_data[r*W +: W] = d;
        bus.req[r] = 1'b1;
    endtask

    // Waits (bounded) for an ack; lat = edges after the grant edge, -1 on expiry.
    task automatic wait_ack(output rsp_t obs, output int lat);
        obs = '0; lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (bus.ack != 2'b00) begin
                obs = {bus.ack, bus.rsp_data, bus.rsp_timeout};
                lat = i;
                break;
            end
        end
        bus.req = bus.req & ~obs[14:13];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [50:0] o;
        bus.req = 2'b00; bus.req_op = '0; bus.req_mask = '0; bus.req_data = '0; ext_pins = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        o = {bus.ack, bus.rsp_data, bus.rsp_timeout, bus.gpio_address, bus.gpio_chipselect, bus.gpio_write_n, bus.gpio_writedata};
        checks++; if (o !== RST_VEC) $display("FAIL reset_in: got %h want %h", o, RST_VEC); else passes++;
        reset_n = 1'b1;
        @(posedge clk); #1;
        o = {bus.ack, bus.rsp_data, bus.rsp_timeout, bus.gpio_address, bus.gpio_chipselect, bus.gpio_write_n, bus.gpio_writedata};
        checks++; if (o !== RST_VEC) $display("FAIL reset_after: got %h want %h", o, RST_VEC); else passes++;
    endtask

    task automatic test_write_dir();
        rsp_t obs, e; int lat, w0;
        w0 = wr_cnt;
        exp_dir = rmw(exp_dir, 12'hFFF, 12'h0F0);
        sb_q.push_back({2'b01, exp_dir, 1'b0});
        issue(0, WR_DIR, 12'hFFF, 12'h0F0);
        wait_ack(obs, lat);
        e = sb_q.pop_front();
        checks++; if (obs !== e) $display("FAIL wdir_rsp: got %h want %h", obs, e); else passes++;
        checks++; if (lat !== 2) $display("FAIL wdir_latency: got %0d want 2", lat); else passes++;
        checks++; if (wr_cnt - w0 !== 1) $display("FAIL wdir_count: got %0d want 1", wr_cnt - w0); else passes++;
        checks++; if ({last_addr, last_data} !== {2'd1, 32'h0F0}) $display("FAIL wdir_bus: got %0d/%h want 1/0f0", last_addr, last_data); else passes++;
    endtask

    task automatic test_write_out();
        rsp_t obs, e; int lat;
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] m, d;
            m = (k == 0) ? 12'h00F : 12'h0F0;
            d = (k == 0) ? 12'hFFF : 12'h0A0;
            exp_out = rmw(exp_out, m, d);
            sb_q.push_back({(k == 0) ? 2'b01 : 2'b10, exp_out, 1'b0});
            issue(k, WR_OUT, m, d);
            wait_ack(obs, lat);
            e = sb_q.pop_front();
            checks++; if (obs !== e) $display("FAIL wout_rsp%0d: got %h want %h", k, obs, e); else passes++;
            checks++; if ({last_addr, last_data} !== {2'd0, 20'h0, exp_out}) $display("FAIL wout_bus%0d: got %0d/%h want 0/%h", k, last_addr, last_data, exp_out); else passes++;
            checks++; if (lat !== 2) $display("FAIL wout_latency%0d: got %0d want 2", k, lat); else passes++;
        end
        checks++; if (slv_out !== 12'h0AF) $display("FAIL wout_latch: got %h want 0af", slv_out); else passes++;
    endtask

    task automatic test_back_to_back();
        rsp_t obs, e; int lat, w0, b0;
        w0 = wr_cnt; b0 = b2b_cnt;
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] m0, m1, d1;
            m0 = 12'h001 << k;
            m1 = 12'h010 << k;
            d1 = k[0] ? 12'hFFF : 12'h000;
            exp_out = rmw(exp_out, m0, 12'hFFF);
            sb_q.push_back({2'b01, exp_out, 1'b0});
            exp_out = rmw(exp_out, m1, d1);
            sb_q.push_back({2'b10, exp_out, 1'b0});
            issue(0, WR_OUT, m0, 12'hFFF);
            issue(1, WR_OUT, m1, d1);
            for (int j = 0; j < 2; j++) begin
                wait_ack(obs, lat);
                e = sb_q.pop_front();
                checks++; if (obs !== e) $display("FAIL rr_rsp%0d_%0d: got %h want %h", k, j, obs, e); else passes++;
                checks++; if (last_data[W-1:0] !== e[12:1]) $display("FAIL rr_bus%0d_%0d: got %h want %h", k, j, last_data, e[12:1]); else passes++;
            end
        end
        checks++; if (wr_cnt - w0 !== 8) $display("FAIL rr_count: got %0d want 8", wr_cnt - w0); else passes++;
        checks++; if (b2b_cnt - b0 !== 0) $display("FAIL rr_overlap: got %0d want 0", b2b_cnt - b0); else passes++;
        checks++; if (slv_out !== exp_out) $display("FAIL rr_latch: got %h want %h", slv_out, exp_out); else passes++;
    endtask

    task automatic test_read_pins();
        rsp_t obs, e; int lat, w0;
        exp_dir = rmw(exp_dir, 12'hFFF, 12'h000);
        sb_q.push_back({2'b10, exp_dir, 1'b0});
        issue(1, WR_DIR, 12'hFFF, 12'h000);
        wait_ack(obs, lat);
        e = sb_q.pop_front();
        checks++; if (obs !== e) $display("FAIL dir_clear_rsp: got %h want %h", obs, e); else passes++;
        ext_pins = 12'h5A3;
        w0 = wr_cnt;
        sb_q.push_back({2'b01, 12'h503, 1'b0});
        issue(0, RD_PINS, 12'hF0F, 12'h000);
        wait_ack(obs, lat);
        e = sb_q.pop_front();
        checks++; if (obs !== e) $display("FAIL read_rsp: got %h want %h", obs, e); else passes++;
        checks++; if (lat !== 3) $display("FAIL read_latency: got %0d want 3", lat); else passes++;
        checks++; if (wr_cnt - w0 !== 0) $display("FAIL read_nowrite: got %0d want 0", wr_cnt - w0); else passes++;
    endtask

    task automatic test_wait_match();
        rsp_t obs, e; int lat;
        ext_pins = 12'h000;
        sb_q.push_back({2'b01, 12'h001, 1'b0});
        issue(0, WT_PINS, 12'h001, 12'h001);
        fork
            begin repeat (10) @(posedge clk); #1; ext_pins[0] = 1'b1; end
            wait_ack(obs, lat);
        join
        e = sb_q.pop_front();
        checks++; if (obs !== e) $display("FAIL wait_rsp: got %h want %h", obs, e); else passes++;
        // Pin rises after edge N+9; the poll at N+12 is the first to see it.
        checks++; if (lat !== 13) $display("FAIL wait_latency: got %0d want 13", lat); else passes++;
        sb_q.push_back({2'b10, 12'h000, 1'b0});
        issue(1, WT_PINS, 12'h000, 12'hFFF);
        wait_ack(obs, lat);
        e = sb_q.pop_front();
        checks++; if (obs !== e) $display("FAIL wait_mask0_rsp: got %h want %h", obs, e); else passes++;
        checks++; if (lat !== 3) $display("FAIL wait_mask0_latency: got %0d want 3", lat); else passes++;
    endtask

    task automatic test_timeout();
        rsp_t obs, e; int lat;
        ext_pins = 12'h00A;
        sb_q.push_back({2'b10, 12'h00A, 1'b1});
        issue(1, WT_PINS, 12'h00F, 12'h005);
        wait_ack(obs, lat);
        e = sb_q.pop_front();
        checks++; if (obs !== e) $display("FAIL timeout_rsp: got %h want %h", obs, e); else passes++;
        checks++; if (lat !== 2 * TB_TIMEOUT + 1) $display("FAIL timeout_latency: got %0d want %0d", lat, 2 * TB_TIMEOUT + 1); else passes++;
    endtask

    task automatic test_reset_mid();
        rsp_t obs, e; int lat;
        logic [50:0] o;
        issue(0, WR_OUT, 12'hFFF, 12'h5A5);
        @(posedge clk); #1;
        checks++; if ({bus.gpio_chipselect, bus.gpio_write_n} !== 2'b10) $display("FAIL mid_in_wr: got %b want 10", {bus.gpio_chipselect, bus.gpio_write_n}); else passes++;
        reset_n = 1'b0;
        bus.req = 2'b00;
        #1;
        o = {bus.ack, bus.rsp_data, bus.rsp_timeout, bus.gpio_address, bus.gpio_chipselect, bus.gpio_write_n, bus.gpio_writedata};
        checks++; if (o !== RST_VEC) $display("FAIL mid_reset_vals: got %h want %h", o, RST_VEC); else passes++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_out = '0; exp_dir = '0;
        @(posedge clk); #1;
        exp_out = rmw(exp_out, 12'h00F, 12'h003);
        sb_q.push_back({2'b01, exp_out, 1'b0});
        issue(0, WR_OUT, 12'h00F, 12'h003);
        wait_ack(obs, lat);
        e = sb_q.pop_front();
        checks++; if (obs !== e) $display("FAIL mid_next_rsp: got %h want %h", obs, e); else passes++;
        checks++; if (last_data !== 32'h003) $display("FAIL mid_next_bus: got %h want 003", last_data); else passes++;
        checks++; if (slv_out !== 12'h003) $display("FAIL mid_next_latch: got %h want 003", slv_out); else passes++;
    endtask

    initial begin
        test_reset();
        test_write_dir();
        test_write_out();
        test_back_to_back();
        test_read_pins();
        test_wait_match();
        test_timeout();
        test_reset_mid();
        checks++; if (sb_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d want 0", sb_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
